// File: rtl/wbq_pkg.sv
// rtl/wbq_pkg.sv - shared defaults and types for the write-back queue
package wbq_pkg;

  localparam int WBQ_W     = 8;
  localparam int WBQ_D     = 4;
  localparam int WBQ_DEPTH = 4;

  // Register 2**D-1 is hardwired to zero, so writes to it are dropped.
  localparam logic [WBQ_D-1:0] ZERO_REG = WBQ_D'(2**WBQ_D - 1);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

  typedef struct packed {
    logic [WBQ_D-1:0] addr;
    logic [WBQ_W-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// rtl/wbq_fifo.sv - circular {addr,data} store with head view and raw entry taps
module wbq_fifo #(
  parameter int W     = 8,
  parameter int D     = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [D-1:0]                 push_addr_i,
  input  logic [W-1:0]                 push_data_i,
  input  logic                         pop_i,
  output logic [D-1:0]                 head_addr_o,
  output logic [W-1:0]                 head_data_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH)-1:0]     rd_ptr_o,
  output logic [DEPTH-1:0][D-1:0]      mem_addr_o,
  output logic [DEPTH-1:0][W-1:0]      mem_data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][D-1:0] addr_q;
  logic [DEPTH-1:0][W-1:0] data_q;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        addr_q[wr_ptr_q] <= push_addr_i;
        data_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign rd_ptr_o    = rd_ptr_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - two-source register write-back queue with round-robin arbitration
// Optional youngest-match bypass lookup enabled by macro WBQ_BYPASS_EN.
module wb_queue
  import wbq_pkg::*;
#(
  parameter int W     = WBQ_W,
  parameter int D     = WBQ_D,
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [D-1:0]           alu_addr,
  input  logic [W-1:0]           alu_data,
  output logic                   alu_ready,
  input  logic                   ld_valid,
  input  logic [D-1:0]           ld_addr,
  input  logic [W-1:0]           ld_data,
  output logic                   ld_ready,
  input  logic                   rf_hold,
  output logic                   rf_write_en,
  output logic [D-1:0]           rf_waddr,
  output logic [W-1:0]           rf_data,
  input  logic [D-1:0]           raddrA,
  input  logic [D-1:0]           raddrB,
  output logic                   byp_hitA,
  output logic                   byp_hitB,
  output logic [W-1:0]           byp_dataA,
  output logic [W-1:0]           byp_dataB,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [D-1:0] ZERO_ADDR = '1;

  src_e                    rr_q, rr_d;
  logic                    grant_alu, grant_ld, push, pop, full, empty;
  logic [D-1:0]            push_addr, head_addr;
  logic [W-1:0]            push_data, head_data;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count_w;
  logic [DEPTH-1:0][D-1:0] mem_addr;
  logic [DEPTH-1:0][W-1:0] mem_data;

  // Full is checked against the pre-pop count; reset low blocks every grant.
  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (reset && !full) begin
      if (alu_valid && ld_valid) begin
        grant_ld  = (rr_q == SRC_LD);
        grant_alu = (rr_q == SRC_ALU);
      end else begin
        grant_alu = alu_valid;
        grant_ld  = ld_valid;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_ld)       rr_d = SRC_ALU;
    else if (grant_alu) rr_d = SRC_LD;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= SRC_LD;
    else        rr_q <= rr_d;
  end

  assign alu_ready = grant_alu;
  assign ld_ready  = grant_ld;
  assign push_addr = grant_ld ? ld_addr : alu_addr;
  assign push_data = grant_ld ? ld_data : alu_data;
  assign push      = (grant_alu || grant_ld) && (push_addr != ZERO_ADDR);
  assign pop       = !empty && !rf_hold;

  wbq_fifo #(.W(W), .D(D), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_ni      (reset),
    .push_i      (push),
    .push_addr_i (push_addr),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (count_w),
    .full_o      (full),
    .empty_o     (empty),
    .rd_ptr_o    (rd_ptr),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data)
  );

  assign rf_write_en = pop;
  assign rf_waddr    = head_addr;
  assign rf_data     = head_data;
  assign count       = count_w;

`ifdef WBQ_BYPASS_EN
  logic [AW-1:0] idx;

  // Walk oldest to youngest so a later match overwrites an earlier one.
  always_comb begin
    byp_hitA  = 1'b0;
    byp_hitB  = 1'b0;
    byp_dataA = '0;
    byp_dataB = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + AW'(k);
      if (CW'(k) < count_w) begin
        if (mem_addr[idx] == raddrA && raddrA != ZERO_ADDR) begin
          byp_hitA  = 1'b1;
          byp_dataA = mem_data[idx];
        end
        if (mem_addr[idx] == raddrB && raddrB != ZERO_ADDR) begin
          byp_hitB  = 1'b1;
          byp_dataB = mem_data[idx];
        end
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{raddrA, raddrB, rd_ptr, mem_addr, mem_data};
  assign byp_hitA   = 1'b0;
  assign byp_hitB   = 1'b0;
  assign byp_dataA  = '0;
  assign byp_dataB  = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - directed vector bench for wb_queue
module tb_wb_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid, ld_valid, rf_hold;
  logic [3:0] alu_addr, ld_addr, raddrA, raddrB;
  logic [7:0] alu_data, ld_data;
  logic       alu_ready, ld_ready, rf_write_en, byp_hitA, byp_hitB;
  logic [3:0] rf_waddr;
  logic [7:0] rf_data, byp_dataA, byp_dataB;
  logic [2:0] count;

`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic av; logic [3:0] aa; logic [7:0] ad;
    logic lv; logic [3:0] la; logic [7:0] ldd;
    logic hold; logic [3:0] ra; logic [3:0] rb;
    logic ear; logic elr; logic ewe; logic [3:0] ewa; logic [7:0] ewd;
    logic [2:0] ecnt; logic eha; logic [7:0] eda; logic ehb; logic [7:0] edb;
  } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];
  int n_cmp = 0;
  int n_err = 0;

  wb_queue #(.W(8), .D(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_hold(rf_hold), .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_data(rf_data),
    .raddrA(raddrA), .raddrB(raddrB),
    .byp_hitA(byp_hitA), .byp_hitB(byp_hitB), .byp_dataA(byp_dataA), .byp_dataB(byp_dataB),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
  endtask

  initial begin
    //       av aa    ad     lv la    ld     hd ra    rb     ar lr we wa    wd     cnt   ha da     hb db
    tv[0]  = '{1, 4'd3, 8'h5A, 0, 4'd0, 8'h00, 0, 4'd3, 4'd15, 1, 0, 0, 4'd0, 8'h00, 3'd0, 0, 8'h00, 0, 8'h00};
    tv[1]  = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd3, 4'd15, 0, 0, 1, 4'd3, 8'h5A, 3'd1, 1, 8'h5A, 0, 8'h00};
    tv[2]  = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd3, 4'd15, 0, 0, 0, 4'd0, 8'h00, 3'd0, 0, 8'h00, 0, 8'h00};
    tv[3]  = '{1, 4'd1, 8'hA0, 1, 4'd2, 8'hB0, 1, 4'd2, 4'd1,  0, 1, 0, 4'd0, 8'h00, 3'd0, 0, 8'h00, 0, 8'h00};
    tv[4]  = '{1, 4'd1, 8'hA1, 1, 4'd2, 8'hB1, 1, 4'd2, 4'd1,  1, 0, 0, 4'd2, 8'hB0, 3'd1, 1, 8'hB0, 0, 8'h00};
    tv[5]  = '{1, 4'd1, 8'hA2, 1, 4'd2, 8'hB2, 1, 4'd2, 4'd1,  0, 1, 0, 4'd2, 8'hB0, 3'd2, 1, 8'hB0, 1, 8'hA1};
    tv[6]  = '{1, 4'd1, 8'hA3, 1, 4'd2, 8'hB3, 1, 4'd2, 4'd1,  1, 0, 0, 4'd2, 8'hB0, 3'd3, 1, 8'hB2, 1, 8'hA1};
    tv[7]  = '{1, 4'd1, 8'hA4, 1, 4'd2, 8'hB4, 1, 4'd2, 4'd1,  0, 0, 0, 4'd2, 8'hB0, 3'd4, 1, 8'hB2, 1, 8'hA3};
    tv[8]  = '{1, 4'd1, 8'hA4, 1, 4'd2, 8'hB4, 0, 4'd2, 4'd1,  0, 0, 1, 4'd2, 8'hB0, 3'd4, 1, 8'hB2, 1, 8'hA3};
    tv[9]  = '{1, 4'd1, 8'hA5, 1, 4'd2, 8'hB5, 0, 4'd2, 4'd1,  0, 1, 1, 4'd1, 8'hA1, 3'd3, 1, 8'hB2, 1, 8'hA3};
    tv[10] = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd2, 4'd1,  0, 0, 1, 4'd2, 8'hB2, 3'd3, 1, 8'hB5, 1, 8'hA3};
    tv[11] = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd2, 4'd1,  0, 0, 1, 4'd1, 8'hA3, 3'd2, 1, 8'hB5, 1, 8'hA3};
    tv[12] = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd2, 4'd1,  0, 0, 1, 4'd2, 8'hB5, 3'd1, 1, 8'hB5, 0, 8'h00};
    tv[13] = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 4'd2, 4'd1,  0, 0, 0, 4'd1, 8'hA1, 3'd0, 0, 8'h00, 0, 8'h00};
    tv[14] = '{1, 4'd7, 8'h11, 0, 4'd0, 8'h00, 1, 4'd7, 4'd15, 1, 0, 0, 4'd1, 8'hA1, 3'd0, 0, 8'h00, 0, 8'h00};
    tv[15] = '{0, 4'd0, 8'h00, 1, 4'd7, 8'h22, 1, 4'd7, 4'd15, 0, 1, 0, 4'd7, 8'h11, 3'd1, 1, 8'h11, 0, 8'h00};
    tv[16] = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, 4'd7, 4'd15, 0, 0, 0, 4'd7, 8'h11, 3'd2, 1, 8'h22, 0, 8'h00};
    tv[17] = '{0, 4'd0, 8'h00, 1, 4'd15, 8'hFF, 1, 4'd7, 4'd15, 0, 1, 0, 4'd7, 8'h11, 3'd2, 1, 8'h22, 0, 8'h00};
    tv[18] = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, 4'd7, 4'd15, 0, 0, 0, 4'd7, 8'h11, 3'd2, 1, 8'h22, 0, 8'h00};
    tv[19] = '{1, 4'd5, 8'h55, 0, 4'd0, 8'h00, 1, 4'd7, 4'd15, 1, 0, 0, 4'd7, 8'h11, 3'd2, 1, 8'h22, 0, 8'h00};
    tv[20] = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, 4'd7, 4'd15, 0, 0, 0, 4'd7, 8'h11, 3'd3, 1, 8'h22, 0, 8'h00};

    reset = 1'b0;
    idle_inputs();
    alu_valid = 1'b1; ld_valid = 1'b1;
    rf_hold = 1'b0; raddrA = 4'd3; raddrB = 4'd1;
    @(negedge clk);
    #1;
    chk("rst_alu_ready", 0, alu_ready, 0);
    chk("rst_ld_ready", 0, ld_ready, 0);
    chk("rst_count", 0, count, 0);
    chk("rst_we", 0, rf_write_en, 0);
    chk("rst_waddr", 0, rf_waddr, 0);
    chk("rst_data", 0, rf_data, 0);
    chk("rst_hitA", 0, byp_hitA, 0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      alu_valid = tv[i].av; alu_addr = tv[i].aa; alu_data = tv[i].ad;
      ld_valid  = tv[i].lv; ld_addr  = tv[i].la; ld_data  = tv[i].ldd;
      rf_hold   = tv[i].hold; raddrA = tv[i].ra; raddrB = tv[i].rb;
      #1;
      chk("alu_ready", i, alu_ready, tv[i].ear);
      chk("ld_ready", i, ld_ready, tv[i].elr);
      chk("rf_write_en", i, rf_write_en, tv[i].ewe);
      chk("rf_waddr", i, rf_waddr, tv[i].ewa);
      chk("rf_data", i, rf_data, tv[i].ewd);
      chk("count", i, count, tv[i].ecnt);
      chk("byp_hitA", i, byp_hitA, BYP ? tv[i].eha : 1'b0);
      chk("byp_dataA", i, byp_dataA, BYP ? tv[i].eda : 8'h00);
      chk("byp_hitB", i, byp_hitB, BYP ? tv[i].ehb : 1'b0);
      chk("byp_dataB", i, byp_dataB, BYP ? tv[i].edb : 8'h00);
    end

    // Three entries pending; release hold then pull reset mid-cycle.
    @(negedge clk);
    idle_inputs();
    rf_hold = 1'b0;
    #1;
    chk("pre_rst_we", 0, rf_write_en, 1);
    chk("pre_rst_count", 0, count, 3);
    chk("pre_rst_waddr", 0, rf_waddr, 7);
    #1 reset = 1'b0;
    #1;
    chk("async_count", 0, count, 0);
    chk("async_we", 0, rf_write_en, 0);
    chk("async_waddr", 0, rf_waddr, 0);
    chk("async_data", 0, rf_data, 0);
    chk("async_hitA", 0, byp_hitA, 0);
    alu_valid = 1'b1; ld_valid = 1'b1;
    #1;
    chk("async_alu_ready", 0, alu_ready, 0);
    chk("async_ld_ready", 0, ld_ready, 0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("post_rst_we", 0, rf_write_en, 0);
    chk("post_rst_count", 0, count, 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_we", k, rf_write_en, 0);
      chk("post_rst_count", k, count, 0);
    end

    // Round-robin must favour ld again after reset.
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 8'hC1;
    ld_valid  = 1'b1; ld_addr  = 4'd2; ld_data  = 8'hC2;
    #1;
    chk("rr_ld_ready", 0, ld_ready, 1);
    chk("rr_alu_ready", 0, alu_ready, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rr_count", 0, count, 1);
    chk("rr_we", 0, rf_write_en, 1);
    chk("rr_waddr", 0, rf_waddr, 2);
    chk("rr_data", 0, rf_data, 8'hC2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
